// File: rtl/udp_arb_pkg.sv
// Shared definitions for the UDP reply arbiter: FSM state encoding and link-layer address width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package udp_arb_pkg;

    localparam int LL_ADDR_W = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        XFER  = 2'd2,
        FLUSH = 2'd3
    } arb_state_e;

endpackage

// File: rtl/udp_rr_arbiter.sv
// Round-robin channel picker: first requesting channel strictly after last_grant, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to take the grant.
module udp_rr_arbiter
    import udp_arb_pkg::*;
#(
    parameter int NUM_CH = 3
) (
    input  logic [NUM_CH-1:0]    req_i,
    input  logic [LL_ADDR_W-1:0] last_grant_i,
    output logic [LL_ADDR_W-1:0] grant_o,
    output logic                 any_req_o
);

    logic                 hi_found;
    logic                 lo_found;
    logic [LL_ADDR_W-1:0] hi_idx;
    logic [LL_ADDR_W-1:0] lo_idx;

    // Two candidates: lowest requester above last_grant, else lowest at or below it (the wrap).
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            if (req_i[j]) begin
                if (j > int'(last_grant_i)) begin
                    if (!hi_found) begin
                        hi_found = 1'b1;
                        hi_idx   = LL_ADDR_W'(j);
                    end
                end else if (!lo_found) begin
                    lo_found = 1'b1;
                    lo_idx   = LL_ADDR_W'(j);
                end
            end
        end
        any_req_o = |req_i;
        grant_o   = hi_found ? hi_idx : lo_idx;
    end

endmodule

// File: rtl/udp_reply_arb.sv
// Multiplexes NUM_CH upstream UDP reply FIFOs onto one downstream LocalLink port, truncating frames at MAX_FRAME_LEN (optional counters via UDP_REPLY_ARB_STATS_EN).
// Latency: one IDLE + one GRANT cycle per frame, then zero-latency combinational forwarding of data.
// Backpressure: downstream dst_rdy_n passes straight upstream while the bus selects this block; otherwise both sides stall.
module udp_reply_arb
    import udp_arb_pkg::*;
#(
    parameter int                   NUM_CH        = 3,
    parameter logic [LL_ADDR_W-1:0] UDP_FIFO_ADDR = 6'd0,
    parameter int                   MAX_FRAME_LEN = 1472
) (
    input  logic                 udp_sw_tx_clk,
    input  logic                 reset_n,
    input  logic [NUM_CH-1:0]    udp_ch_avail,
    input  logic                 udp_tx_rd_sof_n,
    input  logic [7:0]           udp_tx_rd_data_out,
    input  logic                 udp_tx_rd_eof_n,
    input  logic                 udp_tx_rd_src_rdy_n,
    output logic                 udp_tx_rd_dst_rdy_n,
    output logic [LL_ADDR_W-1:0] udp_tx_rd_fifo_addr,
    output logic                 udp_sw_tx_sof_n,
    output logic [7:0]           udp_sw_tx_data_out,
    output logic                 udp_sw_tx_eof_n,
    output logic                 udp_sw_tx_src_rdy_n,
    input  logic                 udp_sw_tx_dst_rdy_n,
    input  logic [LL_ADDR_W-1:0] udp_sw_tx_fifo_rd_addr
`ifdef UDP_REPLY_ARB_STATS_EN
    ,
    output logic [31:0]          frame_cnt,
    output logic [15:0]          trunc_cnt
`endif
);

    localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME_LEN);

    arb_state_e           state_q, state_d;
    logic [LL_ADDR_W-1:0] last_grant_q, last_grant_d;
    logic [LL_ADDR_W-1:0] grant_q, grant_d;
    logic [15:0]          cnt_q, cnt_d;

    logic [LL_ADDR_W-1:0] arb_grant;
    logic                 arb_any;
    logic                 bus_sel;
    logic                 xfer_beat;
    logic                 flush_beat;
    logic [15:0]          cnt_inc;
    logic                 at_limit;

    udp_rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
        .req_i        (udp_ch_avail),
        .last_grant_i (last_grant_q),
        .grant_o      (arb_grant),
        .any_req_o    (arb_any)
    );

    // A downstream beat only exists while the shared bus addresses us; upstream sees the same handshake.
    assign bus_sel    = (udp_sw_tx_fifo_rd_addr == UDP_FIFO_ADDR);
    assign xfer_beat  = (state_q == XFER) && bus_sel && !udp_tx_rd_src_rdy_n && !udp_sw_tx_dst_rdy_n;
    assign flush_beat = (state_q == FLUSH) && !udp_tx_rd_src_rdy_n;
    assign cnt_inc    = cnt_q + 16'd1;
    assign at_limit   = (cnt_inc == MAX_LEN);

    assign udp_tx_rd_fifo_addr = grant_q;

    // State register; reset abandons any frame in flight.
    always_ff @(posedge udp_sw_tx_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= LL_ADDR_W'(NUM_CH - 1);
            grant_q      <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            cnt_q        <= cnt_d;
        end
    end

    // Next state and port drive: forward in XFER, swallow the tail in FLUSH, quiet everywhere else.
    always_comb begin
        state_d             = state_q;
        last_grant_d        = last_grant_q;
        grant_d             = grant_q;
        cnt_d               = cnt_q;
        udp_tx_rd_dst_rdy_n = 1'b1;
        udp_sw_tx_sof_n     = 1'b1;
        udp_sw_tx_data_out  = 8'h00;
        udp_sw_tx_eof_n     = 1'b1;
        udp_sw_tx_src_rdy_n = 1'b1;
        case (state_q)
            IDLE: begin
                // Availability is only looked at here, so a flag that drops later keeps its grant.
                if (arb_any) begin
                    grant_d = arb_grant;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // One dead cycle lets the upstream FIFO mux settle on the new address.
                state_d = XFER;
            end
            XFER: begin
                udp_sw_tx_sof_n    = udp_tx_rd_sof_n;
                udp_sw_tx_data_out = udp_tx_rd_data_out;
                udp_sw_tx_eof_n    = udp_tx_rd_eof_n;
                if (bus_sel) begin
                    udp_sw_tx_src_rdy_n = udp_tx_rd_src_rdy_n;
                    udp_tx_rd_dst_rdy_n = udp_sw_tx_dst_rdy_n;
                end
                if (xfer_beat) begin
                    cnt_d = cnt_inc;
                    if (!udp_tx_rd_eof_n) begin
                        // A real EOF wins even when it lands exactly on the length limit.
                        last_grant_d = grant_q;
                        state_d      = IDLE;
                    end else if (at_limit) begin
                        udp_sw_tx_eof_n = 1'b0;
                        state_d         = FLUSH;
                    end
                end
            end
            FLUSH: begin
                udp_tx_rd_dst_rdy_n = 1'b0;
                if (flush_beat && !udp_tx_rd_eof_n) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef UDP_REPLY_ARB_STATS_EN
    logic [31:0] frame_cnt_q;
    logic [15:0] trunc_cnt_q;
    logic        frame_done;
    logic        trunc_start;

    assign frame_done  = (xfer_beat && !udp_tx_rd_eof_n) || (flush_beat && !udp_tx_rd_eof_n);
    assign trunc_start = xfer_beat && udp_tx_rd_eof_n && at_limit;
    assign frame_cnt   = frame_cnt_q;
    assign trunc_cnt   = trunc_cnt_q;

    // Saturating statistics: completed frames and truncation events.
    always_ff @(posedge udp_sw_tx_clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_q <= '0;
            trunc_cnt_q <= '0;
        end else begin
            if (frame_done && (frame_cnt_q != '1)) frame_cnt_q <= frame_cnt_q + 32'd1;
            if (trunc_start && (trunc_cnt_q != '1)) trunc_cnt_q <= trunc_cnt_q + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_udp_reply_arb.sv
// Self-checking bench for udp_reply_arb (NUM_CH=3, MAX_FRAME_LEN=8): scoreboard of downstream beats plus scenario tasks.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_udp_reply_arb;

    localparam int NUM_CH = 3;
    localparam int MAXL   = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] avail = '0;
    logic       up_sof_n = 1'b1, up_eof_n = 1'b1, up_src_n = 1'b1;
    logic [7:0] up_dat = '0;
    logic       up_dst_n;
    logic [5:0] up_addr;
    logic       dn_sof_n, dn_eof_n, dn_src_n;
    logic [7:0] dn_dat;
    logic       dn_dst_n = 1'b0;
    logic [5:0] dn_addr = '0;
`ifdef UDP_REPLY_ARB_STATS_EN
    logic [31:0] frame_cnt;
    logic [15:0] trunc_cnt;
`endif

    udp_reply_arb #(.NUM_CH(NUM_CH), .UDP_FIFO_ADDR(6'd0), .MAX_FRAME_LEN(MAXL)) dut (
        .udp_sw_tx_clk          (clk),
        .reset_n                (rst_n),
        .udp_ch_avail           (avail),
        .udp_tx_rd_sof_n        (up_sof_n),
        .udp_tx_rd_data_out     (up_dat),
        .udp_tx_rd_eof_n        (up_eof_n),
        .udp_tx_rd_src_rdy_n    (up_src_n),
        .udp_tx_rd_dst_rdy_n    (up_dst_n),
        .udp_tx_rd_fifo_addr    (up_addr),
        .udp_sw_tx_sof_n        (dn_sof_n),
        .udp_sw_tx_data_out     (dn_dat),
        .udp_sw_tx_eof_n        (dn_eof_n),
        .udp_sw_tx_src_rdy_n    (dn_src_n),
        .udp_sw_tx_dst_rdy_n    (dn_dst_n),
        .udp_sw_tx_fifo_rd_addr (dn_addr)
`ifdef UDP_REPLY_ARB_STATS_EN
        ,
        .frame_cnt              (frame_cnt),
        .trunc_cnt              (trunc_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int dn_beats = 0;
    int frame_no = 0;
    logic [9:0] exp_q[$];   // {sof_n, data, eof_n}

    always @(posedge clk) cyc++;

    function automatic logic [7:0] byte_of(input int f, input int k);
        return 8'(f * 37 + k * 3 + 1);
    endfunction

    // Scoreboard: every downstream beat must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && !dn_src_n && !dn_dst_n) begin
            logic [9:0] e;
            dn_beats++;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL dn_beat unexpected: got sof_n=%b dat=%h eof_n=%b, queue empty", dn_sof_n, dn_dat, dn_eof_n);
            end else begin
                e = exp_q.pop_front();
                if ({dn_sof_n, dn_dat, dn_eof_n} !== e)
                    $display("FAIL dn_beat: got sof_n=%b dat=%h eof_n=%b, want sof_n=%b dat=%h eof_n=%b",
                             dn_sof_n, dn_dat, dn_eof_n, e[9], e[8:1], e[0]);
                else
                    n_pass++;
            end
        end
    end

    task automatic present(input int fid, input int i, input int len);
        up_src_n = 1'b0;
        up_sof_n = (i != 0);
        up_eof_n = (i != len - 1);
        up_dat   = byte_of(fid, i);
    endtask

    task automatic go_idle();
        up_src_n = 1'b1;
        up_sof_n = 1'b1;
        up_eof_n = 1'b1;
        up_dat   = 8'h00;
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        avail    = '0;
        dn_dst_n = 1'b0;
        dn_addr  = '0;
        go_idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Source one upstream frame, queue its expected downstream image, check the channel on its first beat.
    task automatic drive_frame(input int exp_ch, input int len, output int first_cyc, output int eof_cyc);
        int i = 0;
        int budget = 0;
        int fid;
        frame_no++;
        fid = frame_no;
        first_cyc = -1;
        eof_cyc   = -1;
        for (int k = 0; k < len && k < MAXL; k++)
            exp_q.push_back({(k == 0) ? 1'b0 : 1'b1, byte_of(fid, k),
                             (k == len - 1 || k == MAXL - 1) ? 1'b0 : 1'b1});
        present(fid, 0, len);
        while (i < len && budget < 300) begin
            @(negedge clk);
            if (!up_src_n && !up_dst_n) begin
                if (i == 0) begin
                    first_cyc = cyc;
                    n_checks++;
                    if (up_addr !== 6'(exp_ch)) $display("FAIL grant_ch: got %0d, want %0d", up_addr, exp_ch);
                    else n_pass++;
                end
                if (i == len - 1) eof_cyc = cyc;
                i++;
            end
            @(posedge clk);
            #1;
            budget++;
            if (i < len) present(fid, i, len);
            else go_idle();
        end
        if (i < len) begin
            n_checks++;
            $display("FAIL frame_timeout: got %0d beats, want %0d", i, len);
            go_idle();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        avail = 3'b111;
        present(99, 0, 4);
        repeat (2) @(negedge clk);
        n_checks++; if (up_dst_n !== 1'b1) $display("FAIL rst_up_dst: got %b, want 1", up_dst_n); else n_pass++;
        n_checks++; if (up_addr !== 6'd0) $display("FAIL rst_up_addr: got %0d, want 0", up_addr); else n_pass++;
        n_checks++; if ({dn_src_n, dn_sof_n, dn_eof_n} !== 3'b111)
            $display("FAIL rst_dn_ctl: got %b, want 111", {dn_src_n, dn_sof_n, dn_eof_n}); else n_pass++;
        n_checks++; if (dn_dat !== 8'h00) $display("FAIL rst_dn_dat: got %h, want 00", dn_dat); else n_pass++;
`ifdef UDP_REPLY_ARB_STATS_EN
        n_checks++; if (frame_cnt !== 32'd0 || trunc_cnt !== 16'd0)
            $display("FAIL rst_stats: got %0d/%0d, want 0/0", frame_cnt, trunc_cnt); else n_pass++;
`endif
        go_idle();
        apply_reset();
        @(negedge clk);
        n_checks++; if (up_dst_n !== 1'b1) $display("FAIL idle_up_dst: got %b, want 1", up_dst_n); else n_pass++;
    endtask

    task automatic test_round_robin();
        int f[4];
        int e[4];
        int chs[4] = '{0, 1, 2, 0};
        apply_reset();
        avail = 3'b111;
        for (int n = 0; n < 4; n++) drive_frame(chs[n], 4, f[n], e[n]);
        avail = '0;
        for (int n = 1; n < 4; n++) begin
            n_checks++;
            if (f[n] - e[n-1] !== 3) $display("FAIL rr_gap%0d: got %0d cycles, want 3", n, f[n] - e[n-1]);
            else n_pass++;
        end
    endtask

    task automatic test_single_high();
        int f, e;
        apply_reset();
        avail = 3'b100;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (up_addr !== 6'd2 || up_dst_n !== 1'b1)
            $display("FAIL grant_cycle: got addr=%0d dst_n=%b, want addr=2 dst_n=1", up_addr, up_dst_n); else n_pass++;
        drive_frame(2, 4, f, e);
        avail = '0;
    endtask

    task automatic test_sticky_grant();
        int f, e;
        apply_reset();
        avail = 3'b010;
        @(posedge clk);
        #1 avail = '0;
        drive_frame(1, 3, f, e);
    endtask

    task automatic test_truncate();
        int f, e, b0;
        apply_reset();
        avail = 3'b001;
        b0 = dn_beats;
        drive_frame(0, 12, f, e);
        avail = '0;
        n_checks++; if (dn_beats - b0 !== 8) $display("FAIL trunc_beats: got %0d, want 8", dn_beats - b0); else n_pass++;
`ifdef UDP_REPLY_ARB_STATS_EN
        n_checks++; if (trunc_cnt !== 16'd1 || frame_cnt !== 32'd1)
            $display("FAIL trunc_stats: got trunc=%0d frames=%0d, want 1/1", trunc_cnt, frame_cnt); else n_pass++;
`endif
    endtask

    task automatic test_exact_max();
        int f, e, b0;
        apply_reset();
        avail = 3'b001;
        b0 = dn_beats;
        drive_frame(0, 8, f, e);
        drive_frame(0, 3, f, e);
        avail = '0;
        n_checks++; if (dn_beats - b0 !== 11) $display("FAIL exact_beats: got %0d, want 11", dn_beats - b0); else n_pass++;
`ifdef UDP_REPLY_ARB_STATS_EN
        n_checks++; if (trunc_cnt !== 16'd0 || frame_cnt !== 32'd2)
            $display("FAIL exact_stats: got trunc=%0d frames=%0d, want 0/2", trunc_cnt, frame_cnt); else n_pass++;
`endif
    endtask

    task automatic test_bus_select();
        int f, e, b0;
        apply_reset();
        avail = 3'b001;
        b0 = dn_beats;
        fork
            drive_frame(0, 6, f, e);
            begin
                int w = 0;
                while (dn_beats - b0 < 3 && w < 100) begin @(negedge clk); w++; end
                if (w >= 100) begin n_checks++; $display("FAIL bus_wait: got %0d beats, want 3", dn_beats - b0); end
                @(posedge clk);
                #1 dn_addr = 6'd1;
                repeat (5) begin
                    @(negedge clk);
                    n_checks++;
                    if (up_dst_n !== 1'b1 || dn_src_n !== 1'b1)
                        $display("FAIL bus_stall: got dst_n=%b src_n=%b, want 1/1", up_dst_n, dn_src_n);
                    else n_pass++;
                end
                @(posedge clk);
                #1 dn_addr = 6'd0;
            end
        join
        avail = '0;
        n_checks++; if (dn_beats - b0 !== 6) $display("FAIL bus_beats: got %0d, want 6", dn_beats - b0); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        int f, e, k, budget, fid;
        apply_reset();
        avail = 3'b010;
        drive_frame(1, 3, f, e);
        avail = 3'b100;
        frame_no++;
        fid = frame_no;
        for (int j = 0; j < 2; j++) exp_q.push_back({(j == 0) ? 1'b0 : 1'b1, byte_of(fid, j), 1'b1});
        k = 0;
        budget = 0;
        present(fid, 0, 10);
        while (k < 2 && budget < 50) begin
            @(negedge clk);
            if (!up_src_n && !up_dst_n) begin
                if (k == 0) begin
                    n_checks++;
                    if (up_addr !== 6'd2) $display("FAIL abort_ch: got %0d, want 2", up_addr); else n_pass++;
                end
                k++;
            end
            @(posedge clk);
            #1 present(fid, k, 10);
            budget++;
        end
        if (k < 2) begin n_checks++; $display("FAIL abort_timeout: got %0d beats, want 2", k); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({dn_src_n, dn_sof_n, dn_eof_n, up_dst_n} !== 4'hF)
            $display("FAIL mid_rst_ctl: got %b, want 1111", {dn_src_n, dn_sof_n, dn_eof_n, up_dst_n}); else n_pass++;
        n_checks++; if (dn_dat !== 8'h00) $display("FAIL mid_rst_dat: got %h, want 00", dn_dat); else n_pass++;
        n_checks++; if (up_addr !== 6'd0) $display("FAIL mid_rst_addr: got %0d, want 0", up_addr); else n_pass++;
        go_idle();
        avail = 3'b111;
        @(posedge clk);
        #1 rst_n = 1'b1;
        n_checks++; if (exp_q.size() !== 0) $display("FAIL mid_rst_queue: got %0d left, want 0", exp_q.size()); else n_pass++;
        drive_frame(0, 3, f, e);
        avail = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_single_high();
        test_sticky_grant();
        test_truncate();
        test_exact_max();
        test_bus_select();
        test_reset_mid_frame();
        repeat (4) @(posedge clk);
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL final_queue: got %0d left, want 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/udp_reply_arb.md
UDP_REPLY_ARB -- requirements
Module: udp_reply_arb

Interface
REQ-001 SHALL have parameter NUM_CH, default 3, number of UDP reply FIFO channels (1..64).
REQ-002 SHALL have parameter UDP_FIFO_ADDR, default 6'd0, address on which this block answers the downstream bus.
REQ-003 SHALL have parameter MAX_FRAME_LEN, default 1472, byte limit per forwarded frame (16-bit).
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
REQ-005 SHALL have ports:
 udp_sw_tx_clk  in  1  sole clock;
 reset_n  in  1  async active-low reset;
 udp_ch_avail  in  NUM_CH  per-channel complete-frame-available flag;
 udp_tx_rd_sof_n  in  1  upstream start of frame;
 udp_tx_rd_data_out  in  8  upstream data;
 udp_tx_rd_eof_n  in  1  upstream end of frame;
 udp_tx_rd_src_rdy_n  in  1  upstream data valid;
 udp_tx_rd_dst_rdy_n  out  1  upstream accept;
 udp_tx_rd_fifo_addr  out  6  upstream channel select;
 udp_sw_tx_sof_n  out  1  downstream SOF;
 udp_sw_tx_data_out  out  8  downstream data;
 udp_sw_tx_eof_n  out  1  downstream EOF;
 udp_sw_tx_src_rdy_n  out  1  downstream valid;
 udp_sw_tx_dst_rdy_n  in  1  downstream accept;
 udp_sw_tx_fifo_rd_addr  in  6  downstream bus select.

Function
REQ-006 SHALL define a beat as a cycle with src_rdy_n=0 and dst_rdy_n=0 on the same interface.
REQ-007 SHALL implement FSM states IDLE, GRANT, XFER, FLUSH.
REQ-008 IDLE: SHALL move to GRANT when udp_ch_avail != 0, selecting the first set bit strictly after last_grant, wrapping at NUM_CH-1.
REQ-009 SHALL sample udp_ch_avail only in IDLE; a flag dropping after the grant SHALL NOT cancel it.
REQ-010 GRANT: SHALL drive udp_tx_rd_fifo_addr = granted channel and hold dst_rdy_n=1 for exactly one cycle, then enter XFER.
REQ-011 XFER: SHALL forward sof_n/data/eof_n combinationally (zero latency); udp_sw_tx_src_rdy_n = udp_tx_rd_src_rdy_n and udp_tx_rd_dst_rdy_n = udp_sw_tx_dst_rdy_n only while udp_sw_tx_fifo_rd_addr == UDP_FIFO_ADDR, otherwise both held at 1.
REQ-012 SHALL count beats in XFER with a 16-bit counter cleared on entering GRANT.
REQ-013 On an EOF beat in XFER: SHALL update last_grant to the granted channel and return to IDLE next cycle.
REQ-014 On the non-EOF beat where counter+1 == MAX_FRAME_LEN: SHALL force udp_sw_tx_eof_n=0 on that beat and enter FLUSH.
REQ-015 FLUSH: SHALL hold udp_tx_rd_dst_rdy_n=0, udp_sw_tx_src_rdy_n=1, discard upstream beats until the EOF beat, then update last_grant and return to IDLE.
REQ-016 Outside XFER, udp_sw_tx_src_rdy_n, sof_n and eof_n SHALL be 1 and udp_sw_tx_data_out SHALL be 8'h00.
REQ-017 An EOF beat that is also the MAX_FRAME_LEN-th beat SHALL be treated as normal EOF (no FLUSH).

Reset
REQ-018 reset_n=0 SHALL immediately force state IDLE, last_grant=NUM_CH-1, counter=0, udp_tx_rd_fifo_addr=0, udp_tx_rd_dst_rdy_n=1, and all downstream outputs to their REQ-016 values.
REQ-019 Reset mid-frame SHALL abandon the frame; no recovery of the partial frame is attempted.

Configuration
REQ-020 With UDP_REPLY_ARB_STATS_EN defined, SHALL add outputs frame_cnt (32 bits, +1 per frame completed in XFER or FLUSH) and trunc_cnt (16 bits, +1 per FLUSH entry), both saturating and reset to 0; without it these ports and registers SHALL be absent.

Structure
REQ-021 SHALL take the FSM state enum and LL_ADDR_W=6 from a shared package udp_arb_pkg.
REQ-022 SHALL place round-robin selection in sub-module udp_rr_arbiter (inputs: request vector, last_grant; outputs: grant index, any_req).

Verification
REQ-023 NUM_CH=3, avail=3'b111 continuously, 4-byte frames -> grants 0,1,2,0 with a single GRANT cycle between frames.
REQ-024 avail=3'b100 only after reset -> first grant channel 2, udp_tx_rd_fifo_addr=2.
REQ-025 MAX_FRAME_LEN=8, 12-byte frame -> 8 downstream beats, beat 8 has eof_n=0, 4 bytes flushed, trunc_cnt=1 (with macro).
REQ-026 udp_sw_tx_fifo_rd_addr=1 mid-frame for 5 cycles -> both dst_rdy_n and src_rdy_n held 1, no byte lost or duplicated after address returns to 0.
REQ-027 reset_n asserted on beat 3 of 10 -> outputs at reset values same cycle; next frame starts at channel 0.
REQ-028 Exactly 8-byte frame with MAX_FRAME_LEN=8 -> normal EOF, no FLUSH, trunc_cnt stays 0.
